// File: rtl/memory_port_arbiter_if.sv
// Request/response bundle for one SRAM-style port: request fields toward the slave, stall and in-order
// read return back to the master.
interface memory_port_arbiter_if;
    logic        transfer_request;
    logic [31:0] address;
    logic        wren;
    logic [31:0] wrdata;
    logic [3:0]  wrmask;
    logic        wait_request;
    logic        read_data_valid;
    logic [31:0] read_data;

    modport master (
        output transfer_request, address, wren, wrdata, wrmask,
        input  wait_request, read_data_valid, read_data
    );

    modport slave (
        input  transfer_request, address, wren, wrdata, wrmask,
        output wait_request, read_data_valid, read_data
    );
endinterface

// File: rtl/memory_port_arbiter.sv
// Two-requester arbiter (A = fetch, B = load/store) onto one memory port, with a tag FIFO routing
// in-order read returns. Optional macro ARB_ROUND_ROBIN_EN swaps fixed A-priority for round robin.
module memory_port_arbiter #(
    parameter int TAG_DEPTH = 4,
    parameter int TAG_AW    = 2
) (
    input  logic                   i_clkin,
    input  logic                   i_rst_n,
    memory_port_arbiter_if.slave   if_a,
    memory_port_arbiter_if.slave   if_b,
    memory_port_arbiter_if.master  if_m,
    output logic                   o_tag_error
);

    logic [TAG_AW:0]    r_wr_ptr;
    logic [TAG_AW:0]    r_rd_ptr;
    logic [TAG_DEPTH-1:0] r_tags;
    logic               r_tag_error;

    logic w_empty;
    logic w_full;
    logic w_blocked_a;
    logic w_blocked_b;
    logic w_elig_a;
    logic w_elig_b;
    logic w_grant_a;
    logic w_grant_b;
    logic w_wait_a;
    logic w_wait_b;
    logic w_accept_a;
    logic w_accept_b;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[TAG_AW] != r_rd_ptr[TAG_AW]) &&
                     (r_wr_ptr[TAG_AW-1:0] == r_rd_ptr[TAG_AW-1:0]);

    // Only reads need a tag slot; writes pass even when the FIFO is full.
    assign w_blocked_a = ~if_a.wren & w_full;
    assign w_blocked_b = ~if_b.wren & w_full;
    assign w_elig_a    = if_a.transfer_request & ~w_blocked_a;
    assign w_elig_b    = if_b.transfer_request & ~w_blocked_b;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_last;
    assign w_grant_b = w_elig_b & (~w_elig_a | ~r_rr_last);
`else
    assign w_grant_b = w_elig_b & ~w_elig_a;
`endif
    // A holds the grant whenever B does not, so an idle port mirrors A's fields.
    assign w_grant_a = ~w_grant_b;

    assign w_wait_a   = ~w_grant_a | if_m.wait_request | w_blocked_a;
    assign w_wait_b   = ~w_grant_b | if_m.wait_request | w_blocked_b;
    assign w_accept_a = if_a.transfer_request & ~w_wait_a;
    assign w_accept_b = if_b.transfer_request & ~w_wait_b;

    assign w_push = (w_accept_a & ~if_a.wren) | (w_accept_b & ~if_b.wren);
    assign w_pop  = if_m.read_data_valid & ~w_empty;
    assign w_head = r_tags[r_rd_ptr[TAG_AW-1:0]];

    assign if_m.transfer_request = w_elig_a | w_elig_b;
    assign if_m.address          = w_grant_b ? if_b.address : if_a.address;
    assign if_m.wren             = w_grant_b ? if_b.wren    : if_a.wren;
    assign if_m.wrdata           = w_grant_b ? if_b.wrdata  : if_a.wrdata;
    assign if_m.wrmask           = w_grant_b ? if_b.wrmask  : if_a.wrmask;

    assign if_a.wait_request    = w_wait_a;
    assign if_b.wait_request    = w_wait_b;
    assign if_a.read_data_valid = w_pop & ~w_head;
    assign if_b.read_data_valid = w_pop & w_head;
    assign if_a.read_data       = if_m.read_data;
    assign if_b.read_data       = if_m.read_data;

    assign o_tag_error = r_tag_error;

    always_ff @(posedge i_clkin or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tags      <= '0;
            r_tag_error <= 1'b0;
        end else begin
            if (w_push) begin
                r_tags[r_wr_ptr[TAG_AW-1:0]] <= w_grant_b;
                r_wr_ptr <= r_wr_ptr + (TAG_AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (TAG_AW+1)'(1);
            end
            // A return with nothing outstanding has no owner; flag it and leave the pointers alone.
            if (if_m.read_data_valid && w_empty) begin
                r_tag_error <= 1'b1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge i_clkin or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_last <= 1'b1;
        end else if (w_accept_a) begin
            r_rr_last <= 1'b0;
        end else if (w_accept_b) begin
            r_rr_last <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: expected read returns go into a scoreboard queue that a
// negedge monitor drains; a small memory model answers accepted reads one cycle later.
module tb_memory_port_arbiter;

    typedef struct {
        bit          owner;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tag_error;

    always #5 clk = ~clk;

    memory_port_arbiter_if if_a();
    memory_port_arbiter_if if_b();
    memory_port_arbiter_if if_m();

    memory_port_arbiter #(.TAG_DEPTH(4), .TAG_AW(2)) dut (
        .i_clkin    (clk),
        .i_rst_n    (rst_n),
        .if_a       (if_a),
        .if_b       (if_b),
        .if_m       (if_m),
        .o_tag_error(tag_error)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   acc_a = 0;
    int   acc_b = 0;
    bit   ord_log[$];
    logic [31:0] pend[$];
    logic [31:0] mem_addr;
    int   budget = 1000000;
    bit   inj = 1'b0;
    int   flush_req = 0;
    int   flush_seen = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic push_exp(bit o, logic [31:0] d);
        exp_t e;
        e.owner = o;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
        #1;
    endtask

    task automatic req_a(bit r, logic [31:0] ad, bit w);
        if_a.transfer_request = r;
        if_a.address          = ad;
        if_a.wren             = w;
        if_a.wrdata           = 32'hC0DE_0000 | ad;
        if_a.wrmask           = 4'hF;
    endtask

    task automatic req_b(bit r, logic [31:0] ad, bit w);
        if_b.transfer_request = r;
        if_b.address          = ad;
        if_b.wren             = w;
        if_b.wrdata           = 32'hB0DE_0000 | ad;
        if_b.wrmask           = 4'h3;
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((exp_q.size() != 0 || pend.size() != 0) && n < 20) begin
            step(1);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset;
        step(1);
        rst_n = 1'b0;
        flush_req++;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    // Memory model: records accepted reads at negedge, returns them in order one cycle later.
    initial begin
        if_m.read_data_valid = 1'b0;
        if_m.read_data       = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && if_m.transfer_request && !if_m.wait_request && !if_m.wren)
                pend.push_back(if_m.address);
            @(posedge clk);
            #2;
            if (flush_req != flush_seen) begin
                pend.delete();
                flush_seen = flush_req;
            end
            if (inj) begin
                if_m.read_data_valid = 1'b1;
                if_m.read_data       = 32'h1234_5678;
            end else if (budget > 0 && pend.size() > 0) begin
                mem_addr = pend.pop_front();
                if_m.read_data_valid = 1'b1;
                if_m.read_data       = mem_data(mem_addr);
                budget--;
            end else begin
                if_m.read_data_valid = 1'b0;
            end
        end
    end

    // Monitor: counts acceptances and checks each returned word against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_a.transfer_request && !if_a.wait_request) begin
                acc_a++;
                ord_log.push_back(1'b0);
            end
            if (if_b.transfer_request && !if_b.wait_request) begin
                acc_b++;
                ord_log.push_back(1'b1);
            end
        end
        if (if_a.read_data_valid || if_b.read_data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ret_unexpected: got a_valid=%0b b_valid=%0b want none",
                         if_a.read_data_valid, if_b.read_data_valid);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ret_both_valid", 32'(if_a.read_data_valid & if_b.read_data_valid), 0);
                chk("ret_owner", 32'(if_b.read_data_valid), 32'(mon_e.owner));
                chk("ret_data", mon_e.owner ? if_b.read_data : if_a.read_data, mon_e.data);
            end
        end
    end

    initial begin
        int a0;
        int b0;
        int idx;

        req_a(1'b0, 32'h0, 1'b0);
        req_b(1'b0, 32'h0, 1'b0);
        if_m.wait_request = 1'b0;

        #2;
        chk("rst_a_wait", 32'(if_a.wait_request), 0);
        chk("rst_a_valid", 32'(if_a.read_data_valid), 0);
        chk("rst_b_valid", 32'(if_b.read_data_valid), 0);
        chk("rst_m_req", 32'(if_m.transfer_request), 0);
        chk("rst_tag_error", 32'(tag_error), 0);
        if_m.wait_request = 1'b1;
        #1;
        chk("rst_a_wait_follows_m", 32'(if_a.wait_request), 1);
        if_m.wait_request = 1'b0;
        rst_n = 1'b1;
        step(1);

        // single read from A
        a0 = acc_a;
        req_a(1'b1, 32'h100, 1'b0);
        push_exp(1'b0, 32'hDEADBEEF);
        step(1);
        req_a(1'b0, 32'h0, 1'b0);
        step(3);
        chk("t1_accepts", acc_a - a0, 1);
        drain("t1_drain");

        // contention for three cycles
        do_reset();
        a0  = acc_a;
        b0  = acc_b;
        idx = ord_log.size();
        req_a(1'b1, 32'h200, 1'b0);
        req_b(1'b1, 32'h300, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
        push_exp(1'b0, 32'hA5A5_0200);
        push_exp(1'b1, 32'hA5A5_0300);
        push_exp(1'b0, 32'hA5A5_0200);
`else
        push_exp(1'b0, 32'hA5A5_0200);
        push_exp(1'b0, 32'hA5A5_0200);
        push_exp(1'b0, 32'hA5A5_0200);
`endif
        for (int i = 0; i < 3; i++) begin
            sample();
`ifndef ARB_ROUND_ROBIN_EN
            chk("t2_b_wait", 32'(if_b.wait_request), 1);
`endif
            step(1);
        end
        req_a(1'b0, 32'h0, 1'b0);
        req_b(1'b0, 32'h0, 1'b0);
        step(1);
`ifdef ARB_ROUND_ROBIN_EN
        chk("t2_order0", 32'(ord_log[idx]), 0);
        chk("t2_order1", 32'(ord_log[idx+1]), 1);
        chk("t2_order2", 32'(ord_log[idx+2]), 0);
`else
        chk("t2_a_accepts", acc_a - a0, 3);
        chk("t2_b_accepts", acc_b - b0, 0);
`endif
        drain("t2_drain");

        // tag routing A,B,B,A
        do_reset();
        push_exp(1'b0, 32'hA5A5_0010);
        push_exp(1'b1, 32'hA5A5_0020);
        push_exp(1'b1, 32'hA5A5_0024);
        push_exp(1'b0, 32'hA5A5_0014);
        req_a(1'b1, 32'h10, 1'b0);
        step(1);
        req_a(1'b0, 32'h0, 1'b0);
        req_b(1'b1, 32'h20, 1'b0);
        step(1);
        req_b(1'b1, 32'h24, 1'b0);
        step(1);
        req_b(1'b0, 32'h0, 1'b0);
        req_a(1'b1, 32'h14, 1'b0);
        step(1);
        req_a(1'b0, 32'h0, 1'b0);
        drain("t3_drain");

        // FIFO full: reads blocked, writes still pass
        do_reset();
        budget = 0;
        a0 = acc_a;
        b0 = acc_b;
        for (int i = 0; i < 4; i++) begin
            req_a(1'b1, 32'h40 + 32'(4 * i), 1'b0);
            push_exp(1'b0, 32'hA5A5_0040 + 32'(4 * i));
            step(1);
        end
        req_a(1'b1, 32'h50, 1'b0);
        req_b(1'b1, 32'h80, 1'b1);
        sample();
        chk("t4_a_wait_full", 32'(if_a.wait_request), 1);
        chk("t4_b_write_wait", 32'(if_b.wait_request), 0);
        chk("t4_m_wren", 32'(if_m.wren), 1);
        chk("t4_m_addr", if_m.address, 32'h80);
        step(1);
        req_b(1'b0, 32'h0, 1'b0);
        chk("t4_b_write_accepted", acc_b - b0, 1);
        sample();
        chk("t4_a_wait_still_full", 32'(if_a.wait_request), 1);
        step(1);
        budget = 1;
        push_exp(1'b0, 32'hA5A5_0050);
        sample();
        chk("t4_a_wait_pop_cycle", 32'(if_a.wait_request), 1);
        step(1);
        sample();
        chk("t4_a_wait_after_pop", 32'(if_a.wait_request), 0);
        step(1);
        req_a(1'b0, 32'h0, 1'b0);
        chk("t4_a_accepts", acc_a - a0, 5);
        budget = 1000000;
        drain("t4_drain");

        // reset with two reads outstanding, then an orphan return
        do_reset();
        budget = 0;
        req_a(1'b1, 32'h60, 1'b0);
        step(1);
        req_a(1'b0, 32'h0, 1'b0);
        req_b(1'b1, 32'h64, 1'b0);
        step(1);
        req_b(1'b0, 32'h0, 1'b0);
        step(1);
        rst_n = 1'b0;
        flush_req++;
        step(1);
        rst_n = 1'b1;
        budget = 1000000;
        step(1);
        sample();
        chk("t5_tag_error_cleared", 32'(tag_error), 0);
        step(1);
        inj = 1'b1;
        sample();
        chk("t5_orphan_a_valid", 32'(if_a.read_data_valid), 0);
        chk("t5_orphan_b_valid", 32'(if_b.read_data_valid), 0);
        step(1);
        inj = 1'b0;
        sample();
        chk("t5_tag_error_set", 32'(tag_error), 1);
        step(3);
        chk("t5_tag_error_sticky", 32'(tag_error), 1);

        // memory stall holds A
        do_reset();
        chk("t6_tag_error_reset", 32'(tag_error), 0);
        if_m.wait_request = 1'b1;
        req_a(1'b1, 32'h70, 1'b0);
        a0 = acc_a;
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t6_a_wait_stall", 32'(if_a.wait_request), 1);
            step(1);
        end
        chk("t6_no_accept", acc_a - a0, 0);
        if_m.wait_request = 1'b0;
        push_exp(1'b0, 32'hA5A5_0070);
        sample();
        chk("t6_a_wait_release", 32'(if_a.wait_request), 0);
        step(1);
        req_a(1'b0, 32'h0, 1'b0);
        step(2);
        chk("t6_one_accept", acc_a - a0, 1);
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
